// File: rtl/nexus_nonce_scheduler.sv
// Nonce scheduler for one hash core in a HASHERS-wide bank.
// Steps the nonce presented to the hash pipe, tracks which pipe slots hold
// real work, compares the pipe output against the share target, and queues
// found nonces for a ready/valid consumer.
module nexus_nonce_scheduler #(
  parameter int HASHERS    = 1,
  parameter int COREIDX    = 0,
  parameter int PIPESTAGES = 391,
  parameter int FIFODEPTH  = 4
) (
  input  logic        clk,
  input  logic        HashRst,
  input  logic        WorkValid,
  input  logic [63:0] WorkNonce,
  input  logic        HashEn,
  input  logic [63:0] HashTop,
  input  logic [63:0] Target,
  output logic [63:0] CurNonce,
  output logic        PipeValidIn,
  output logic [63:0] NonceOut,
  output logic        NonceValid,
  input  logic        NonceReady,
  output logic [31:0] FoundCount,
  output logic        Overflow,
  output logic        Wrapped
);

  localparam int              AW        = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam logic [63:0]     LP_STRIDE = 64'(HASHERS);
  localparam logic [63:0]     LP_OFFSET = 64'(COREIDX);
  // Distance between the nonce entering the pipe and the one leaving it.
  localparam logic [63:0]     LP_BACK   = 64'(PIPESTAGES) * 64'(HASHERS);
  localparam logic [AW:0]     LP_DEPTH  = (AW + 1)'(FIFODEPTH);
  localparam logic [PIPESTAGES-1:0] LP_SR_ONE = PIPESTAGES'(1);

  logic [63:0]           r_cur_nonce;
  logic                  r_loaded;
  logic [PIPESTAGES-1:0] r_valid_sr;
  logic [63:0]           r_fifo_mem [FIFODEPTH];
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW:0]           r_count;
  logic [63:0]           r_nonce_out;
  logic [31:0]           r_found_count;
  logic                  r_overflow;
  logic                  r_wrapped;

  logic                  w_advance;
  logic                  w_out_valid;
  logic                  w_found;
  logic [63:0]           w_out_nonce;
  logic [64:0]           w_sum;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic [AW:0]           w_count_next;
  logic [AW-1:0]         w_rd_ptr_next;
  logic [63:0]           w_head_next;

  // Reset and load take the cycle, so an advance only happens when neither is present.
  assign w_advance   = HashEn & r_loaded & ~WorkValid & ~HashRst;
  assign w_out_valid = r_valid_sr[PIPESTAGES-1];
  assign w_out_nonce = r_cur_nonce - LP_BACK;
  // The comparison is qualified by the advance so a stalled pipe never counts the same slot twice.
  assign w_found     = w_advance & w_out_valid & (HashTop <= Target);
  assign w_sum       = {1'b0, r_cur_nonce} + {1'b0, LP_STRIDE};

  assign w_full        = (r_count == LP_DEPTH);
  assign w_pop         = (r_count != '0) & NonceReady;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign w_push        = w_found & (~w_full | w_pop);
  assign w_rd_ptr_next = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
  // When the next head is the slot being written right now, bypass the memory.
  assign w_head_next   = (w_push && (w_rd_ptr_next == r_wr_ptr)) ? w_out_nonce
                                                                  : r_fifo_mem[w_rd_ptr_next];

  // Queue occupancy after this cycle's push and pop.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + (AW + 1)'(1);
      2'b01:   w_count_next = r_count - (AW + 1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Queue storage; entries beyond the occupancy are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= w_out_nonce;
    end
  end

  // Nonce stepping, pipe valid tracking, queue pointers and status flags.
  always_ff @(posedge clk) begin
    if (HashRst) begin
      r_cur_nonce   <= '0;
      r_loaded      <= 1'b0;
      r_valid_sr    <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_nonce_out   <= '0;
      r_found_count <= '0;
      r_overflow    <= 1'b0;
      r_wrapped     <= 1'b0;
    end else if (WorkValid) begin
      r_cur_nonce   <= WorkNonce + LP_OFFSET;
      r_loaded      <= 1'b1;
      r_valid_sr    <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_found_count <= '0;
      r_overflow    <= 1'b0;
      r_wrapped     <= 1'b0;
    end else begin
      if (w_advance) begin
        r_cur_nonce <= w_sum[63:0];
        r_valid_sr  <= (r_valid_sr << 1) | LP_SR_ONE;
        if (w_sum[64]) begin
          r_wrapped <= 1'b1;
        end
      end
      r_rd_ptr <= w_rd_ptr_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_count <= w_count_next;
      // The output register only moves while something is queued, so it holds when empty.
      if (w_count_next != '0) begin
        r_nonce_out <= w_head_next;
      end
      if (w_found && (r_found_count != 32'hFFFF_FFFF)) begin
        r_found_count <= r_found_count + 32'd1;
      end
      if (w_found && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign CurNonce    = r_cur_nonce;
  assign PipeValidIn = r_loaded;
  assign NonceOut    = r_nonce_out;
  assign NonceValid  = (r_count != '0);
  assign FoundCount  = r_found_count;
  assign Overflow    = r_overflow;
  assign Wrapped     = r_wrapped;

endmodule

// File: tb/tb_nexus_nonce_scheduler.sv
// Directed bench for nexus_nonce_scheduler: load, stall, queue full/overflow,
// wrap, threshold boundary and mid-run reset.
module tb_nexus_nonce_scheduler;

  localparam logic [63:0] BASE = 64'h0000_0001_FCAF_C045;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        HashRst = 1'b1;
  logic        WorkValid = 1'b0;
  logic [63:0] WorkNonce = '0;
  logic        HashEn = 1'b0;
  logic [63:0] HashTop = '0;
  logic [63:0] Target = ONES;
  logic        NonceReady = 1'b0;

  logic [63:0] CurNonce, NonceOut;
  logic        PipeValidIn, NonceValid, Overflow, Wrapped;
  logic [31:0] FoundCount;

  logic [63:0] d1_CurNonce, d1_NonceOut;
  logic        d1_PipeValidIn, d1_NonceValid, d1_Overflow, d1_Wrapped;
  logic [31:0] d1_FoundCount;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nexus_nonce_scheduler #(.HASHERS(2), .COREIDX(1), .PIPESTAGES(4), .FIFODEPTH(4)) dut (
    .clk(clk), .HashRst(HashRst), .WorkValid(WorkValid), .WorkNonce(WorkNonce),
    .HashEn(HashEn), .HashTop(HashTop), .Target(Target),
    .CurNonce(CurNonce), .PipeValidIn(PipeValidIn), .NonceOut(NonceOut),
    .NonceValid(NonceValid), .NonceReady(NonceReady), .FoundCount(FoundCount),
    .Overflow(Overflow), .Wrapped(Wrapped)
  );

  nexus_nonce_scheduler #(.HASHERS(2), .COREIDX(0), .PIPESTAGES(4), .FIFODEPTH(4)) dut_c0 (
    .clk(clk), .HashRst(HashRst), .WorkValid(WorkValid), .WorkNonce(WorkNonce),
    .HashEn(HashEn), .HashTop(HashTop), .Target(Target),
    .CurNonce(d1_CurNonce), .PipeValidIn(d1_PipeValidIn), .NonceOut(d1_NonceOut),
    .NonceValid(d1_NonceValid), .NonceReady(NonceReady), .FoundCount(d1_FoundCount),
    .Overflow(d1_Overflow), .Wrapped(d1_Wrapped)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [63:0] nonce);
    WorkValid = 1'b1;
    WorkNonce = nonce;
    tick();
    WorkValid = 1'b0;
    $display("load WorkNonce=0x%016h CurNonce=0x%016h", nonce, CurNonce);
  endtask

  initial begin
    int adv;
    // Reset state
    tick();
    tick();
    HashRst = 1'b0;
    check_eq("rst_cur", CurNonce, 64'h0);
    check_eq("rst_pvi", 64'(PipeValidIn), 64'h0);
    check_eq("rst_nout", NonceOut, 64'h0);
    check_eq("rst_nvalid", 64'(NonceValid), 64'h0);
    check_eq("rst_count", 64'(FoundCount), 64'h0);
    check_eq("rst_ovf", 64'(Overflow), 64'h0);
    check_eq("rst_wrap", 64'(Wrapped), 64'h0);
    // Unloaded core must not advance even with HashEn high
    HashEn = 1'b1;
    tick();
    check_eq("idle_cur", CurNonce, 64'h0);

    // Basic stream: first find 5 cycles after load, then one per cycle
    NonceReady = 1'b1;
    do_load(64'h0000_0001_FCAF_C044);
    check_eq("load_cur", CurNonce, BASE);
    check_eq("load_pvi", 64'(PipeValidIn), 64'h1);
    check_eq("load_nvalid", 64'(NonceValid), 64'h0);
    for (int c = 1; c <= 9; c++) begin
      tick();
      check_eq("s1_cur", CurNonce, BASE + 64'(2 * c));
      if (c < 5) begin
        check_eq("s1_nvalid_early", 64'(NonceValid), 64'h0);
      end else begin
        check_eq("s1_nvalid", 64'(NonceValid), 64'h1);
        check_eq("s1_nout", NonceOut, BASE + 64'(2 * (c - 5)));
        check_eq("s1_count", 64'(FoundCount), 64'(c - 4));
      end
    end

    // Threshold boundary: HashTop just above Target never finds, equal does
    Target  = 64'h100;
    HashTop = 64'h101;
    do_load(64'h0000_0001_FCAF_C044);
    for (int c = 1; c <= 5; c++) tick();
    check_eq("thr_above_nvalid", 64'(NonceValid), 64'h0);
    check_eq("thr_above_count", 64'(FoundCount), 64'h0);
    HashTop = 64'h100;
    tick();
    check_eq("thr_eq_nvalid", 64'(NonceValid), 64'h1);
    check_eq("thr_eq_nout", NonceOut, BASE + 64'd2);
    check_eq("thr_eq_count", 64'(FoundCount), 64'h1);
    Target  = ONES;
    HashTop = 64'h0;

    // Stalls: HashEn alternates, finds stay consecutive with no repeats
    do_load(64'h0000_0001_FCAF_C044);
    adv = 0;
    for (int c = 0; c < 20; c++) begin
      HashEn = (c % 2 == 0);
      tick();
      if (HashEn) adv++;
      if (HashEn && adv >= 5) begin
        check_eq("s2_nvalid", 64'(NonceValid), 64'h1);
        check_eq("s2_nout", NonceOut, BASE + 64'(2 * (adv - 5)));
      end else begin
        check_eq("s2_nvalid_idle", 64'(NonceValid), 64'h0);
      end
    end
    check_eq("s2_count", 64'(FoundCount), 64'd6);
    HashEn = 1'b1;

    // Overflow: fill 4 entries, 5th find is dropped, then drain in order
    NonceReady = 1'b0;
    do_load(64'h0000_0001_FCAF_C044);
    for (int c = 1; c <= 8; c++) tick();
    check_eq("s3_full_ovf", 64'(Overflow), 64'h0);
    check_eq("s3_full_count", 64'(FoundCount), 64'd4);
    tick();
    check_eq("s3_ovf", 64'(Overflow), 64'h1);
    check_eq("s3_count", 64'(FoundCount), 64'd5);
    check_eq("s3_head", NonceOut, BASE);
    HashEn = 1'b0;
    NonceReady = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick();
      check_eq("s3_drain_valid", 64'(NonceValid), 64'h1);
      check_eq("s3_drain_nout", NonceOut, BASE + 64'(2 * j));
    end
    tick();
    check_eq("s3_empty", 64'(NonceValid), 64'h0);
    check_eq("s3_hold", NonceOut, BASE + 64'd6);
    tick();
    check_eq("s3_hold2", NonceOut, BASE + 64'd6);

    // Full queue with simultaneous pop and push: nothing lost
    HashEn = 1'b1;
    NonceReady = 1'b0;
    do_load(64'h0000_0001_FCAF_C044);
    for (int c = 1; c <= 8; c++) tick();
    NonceReady = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      check_eq("s4_nout", NonceOut, BASE + 64'(2 * j));
      check_eq("s4_ovf", 64'(Overflow), 64'h0);
    end
    check_eq("s4_count", 64'(FoundCount), 64'd10);
    HashEn = 1'b0;
    for (int j = 7; j <= 9; j++) begin
      tick();
      check_eq("s4_drain_nout", NonceOut, BASE + 64'(2 * j));
      check_eq("s4_drain_valid", 64'(NonceValid), 64'h1);
    end
    tick();
    check_eq("s4_empty", 64'(NonceValid), 64'h0);

    // Wrap past 2^64-1 on the COREIDX=0 instance
    do_load(64'hFFFF_FFFF_FFFF_FFFE);
    check_eq("wrap_load_cur", d1_CurNonce, 64'hFFFF_FFFF_FFFF_FFFE);
    check_eq("wrap_load_flag", 64'(d1_Wrapped), 64'h0);
    check_eq("wrap_c1_load_cur", CurNonce, 64'hFFFF_FFFF_FFFF_FFFF);
    HashEn = 1'b1;
    tick();
    check_eq("wrap_cur", d1_CurNonce, 64'h0);
    check_eq("wrap_flag", 64'(d1_Wrapped), 64'h1);
    check_eq("wrap_c1_cur", CurNonce, 64'h1);
    tick();
    check_eq("wrap_sticky", 64'(d1_Wrapped), 64'h1);

    // Mid-run reset with queued entries; reset beats a simultaneous load
    NonceReady = 1'b0;
    do_load(64'h0000_0001_FCAF_C044);
    for (int c = 1; c <= 6; c++) tick();
    check_eq("s6_pre_count", 64'(FoundCount), 64'd2);
    check_eq("s6_pre_nvalid", 64'(NonceValid), 64'h1);
    HashRst   = 1'b1;
    WorkValid = 1'b1;
    WorkNonce = 64'h1234;
    tick();
    HashRst   = 1'b0;
    WorkValid = 1'b0;
    check_eq("s6_cur", CurNonce, 64'h0);
    check_eq("s6_pvi", 64'(PipeValidIn), 64'h0);
    check_eq("s6_nout", NonceOut, 64'h0);
    check_eq("s6_nvalid", 64'(NonceValid), 64'h0);
    check_eq("s6_count", 64'(FoundCount), 64'h0);
    check_eq("s6_ovf", 64'(Overflow), 64'h0);
    check_eq("s6_wrap", 64'(d1_Wrapped), 64'h0);
    for (int c = 1; c <= 10; c++) tick();
    check_eq("s6_idle_cur", CurNonce, 64'h0);
    check_eq("s6_idle_nvalid", 64'(NonceValid), 64'h0);
    check_eq("s6_idle_count", 64'(FoundCount), 64'h0);
    check_eq("s6_idle_pvi", 64'(PipeValidIn), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nexus_nonce_scheduler.md
NEXUS_NONCE_SCHEDULER -- requirements
Module: nexus_nonce_scheduler

Interface
REQ-001 SHALL have parameter HASHERS, default 1: number of parallel hash cores sharing the nonce space; this core's nonce stride.
REQ-002 SHALL have parameter COREIDX, default 0, range 0..HASHERS-1: this core's nonce offset.
REQ-003 SHALL have parameter PIPESTAGES, default 391: hash pipe latency in advance cycles, at least 1.
REQ-004 SHALL have parameter FIFODEPTH, default 4, a power of 2 and at least 2: depth of the found-nonce queue.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port HashRst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port WorkValid, input, 1 bit: load a new work packet's starting nonce.
REQ-008 SHALL have port WorkNonce, input, 64 bits: starting nonce of the new work.
REQ-009 SHALL have port HashEn, input, 1 bit: pipe advance enable; the hash pipe stalls when it is low.
REQ-010 SHALL have port HashTop, input, 64 bits: most significant hash word at the pipe output.
REQ-011 SHALL have port Target, input, 64 bits: share threshold.
REQ-012 SHALL have port CurNonce, output, 64 bits: the nonce presented to the hash pipe input.
REQ-013 SHALL have port PipeValidIn, output, 1 bit: CurNonce is valid work.
REQ-014 SHALL have port NonceOut, output, 64 bits: head of the found-nonce queue.
REQ-015 SHALL have port NonceValid, output, 1 bit: the queue is non-empty.
REQ-016 SHALL have port NonceReady, input, 1 bit: the consumer accepts NonceOut.
REQ-017 SHALL have port FoundCount, output, 32 bits: saturating count of found nonces.
REQ-018 SHALL have port Overflow, output, 1 bit: sticky flag, at least one found nonce dropped.
REQ-019 SHALL have port Wrapped, output, 1 bit: sticky flag, the nonce counter wrapped past 2^64-1.

Function
REQ-020 SHALL have an internal Loaded flag: cleared by reset, set by WorkValid; PipeValidIn SHALL equal Loaded.
REQ-021 SHALL, on WorkValid, set CurNonce to WorkNonce+COREIDX (mod 2^64), clear the stage-valid shift register, FIFO, FoundCount, Overflow and Wrapped, and not advance.
REQ-022 SHALL define an advance cycle as HashEn=1, Loaded=1, WorkValid=0 and HashRst=0; only advance cycles change CurNonce or the shift register.
REQ-023 SHALL, on each advance cycle, set CurNonce to CurNonce+HASHERS (mod 2^64), and SHALL set Wrapped when that add carries out.
REQ-024 SHALL, on each advance cycle, shift the PIPESTAGES-bit valid register left one position, shifting in 1.
REQ-025 SHALL treat valid-register bit PIPESTAGES-1 as OutValid; the nonce at the output SHALL be CurNonce-PIPESTAGES*HASHERS (mod 2^64), evaluated before the advance.
REQ-026 SHALL declare a found nonce when an advance cycle has OutValid=1 and HashTop<=Target (unsigned); stalled cycles SHALL never re-evaluate the comparison.
REQ-027 SHALL increment FoundCount on every found nonce, saturating at 0xFFFFFFFF.
REQ-028 SHALL push a found nonce into the FIFO, which becomes visible on NonceOut/NonceValid the next cycle.
REQ-029 SHALL pop the FIFO when NonceValid=1 and NonceReady=1; NonceOut SHALL then present the next entry the following cycle.
REQ-030 SHALL, when the FIFO is full, drop a push with no simultaneous pop and set Overflow.
REQ-031 SHALL, when the FIFO is full and a pop and a push occur in the same cycle, accept both and keep the occupancy unchanged.
REQ-032 SHALL ignore NonceReady when the FIFO is empty; NonceOut SHALL hold its last value while NonceValid=0.
REQ-033 SHALL give priority HashRst > WorkValid > advance.

Reset
REQ-034 SHALL, on HashRst, drive CurNonce=0, PipeValidIn=0, NonceOut=0, NonceValid=0, FoundCount=0, Overflow=0 and Wrapped=0, and clear the valid register, the FIFO and Loaded.
REQ-035 SHALL, when HashRst is asserted mid-operation, abandon all in-flight and queued nonces, and SHALL perform no advance until the next WorkValid.

Verification
REQ-036 SHALL cover this scenario: HASHERS=2, COREIDX=1, PIPESTAGES=4, WorkNonce=0x00000001FCAFC044, HashEn=1, Target=all-ones -> CurNonce=0x00000001FCAFC045 after the load; the first found nonce is 0x00000001FCAFC045 on NonceValid 5 cycles after the load; one found nonce per cycle after that.
REQ-037 SHALL cover this scenario: same setup, HashEn toggled 1,0,1,0 -> found nonces remain consecutive by stride 2 with no duplicates; FoundCount equals the number of advance cycles with OutValid=1.
REQ-038 SHALL cover this scenario: FIFODEPTH=4, NonceReady=0, Target=all-ones -> NonceValid with 4 entries; the 5th find sets Overflow; FoundCount=5; then NonceReady=1 drains the original 4 entries in order.
REQ-039 SHALL cover this scenario: full FIFO with NonceReady=1 held while finds continue -> no Overflow and no loss.
REQ-040 SHALL cover this scenario: WorkNonce=0xFFFFFFFFFFFFFFFE, HASHERS=2, COREIDX=0 -> CurNonce=0x0 after one advance, and Wrapped=1.
REQ-041 SHALL cover this scenario: HashRst asserted with 2 entries queued and a load in flight -> every output at its reset value next cycle, and no finds until WorkValid.
